// File: rtl/pixel_point_op_if.sv
// Valid/ready streaming flit bus shared by the point-operation engine's input and output sides.
interface pixel_point_op_if #(
    parameter int DATA_W = 128
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pixel_point_op.sv
// Streaming per-pixel point operation (invert / threshold / saturating add / passthrough)
// over one block of BLOCK_BEATS flits, with a single output register stage.
module pixel_point_op #(
    parameter int DATA_W      = 128,
    parameter int PIX_W       = 16,
    parameter int MAX_VAL     = 255,
    parameter int BLOCK_BEATS = 32,
    parameter int CNT_W       = $clog2(BLOCK_BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         cfg_mode,
    input  logic [PIX_W-1:0]   cfg_param,
    pixel_point_op_if.slave    in_if,
    pixel_point_op_if.master   out_if,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   beat_cnt
);
    localparam int               LANES     = DATA_W / PIX_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BLOCK_BEATS - 1);
    localparam logic [PIX_W:0]   MAX_EXT   = (PIX_W + 1)'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [PIX_W-1:0]  param_q, param_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] result;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    // Lane arithmetic is one bit wider than a pixel so the saturating add cannot wrap.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PIX_W:0] p;
        logic [PIX_W:0] sum;
        logic [PIX_W:0] r;

        always_comb begin
            p   = {1'b0, in_if.data[k*PIX_W +: PIX_W]};
            sum = p + {1'b0, param_q};
            r   = p;
            case (mode_q)
                2'd0:    r = (p <= MAX_EXT) ? (MAX_EXT - p) : '0;
                2'd1:    r = (p >= {1'b0, param_q}) ? MAX_EXT : '0;
                2'd2:    r = (sum > MAX_EXT) ? MAX_EXT : sum;
                default: r = p;
            endcase
        end

        assign result[k*PIX_W +: PIX_W] = r[PIX_W-1:0];
    end

    always_comb begin
        in_ready    = (state_q == RUN) && (in_cnt_q < LAST_BEAT) && (!out_valid_q || out_if.ready);
        in_fire     = in_if.valid && in_ready;
        out_fire    = out_valid_q && out_if.ready;

        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        mode_d      = mode_q;
        param_d     = param_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    mode_d     = cfg_mode;
                    param_d    = cfg_param;
                    in_cnt_d   = '0;
                    beat_cnt_d = '0;
                end
            end
            RUN:     if (in_fire && (in_cnt_q == LAST_IDX)) state_d = DRAIN;
            DRAIN:   if (out_fire) state_d = DONE;
            default: state_d = IDLE;
        endcase

        // A load in the same cycle as an output handshake replaces the beat without a bubble.
        if (in_fire) begin
            in_cnt_d    = in_cnt_q + 1'b1;
            out_data_d  = result;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (out_fire && (beat_cnt_q != LAST_BEAT)) beat_cnt_d = beat_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            mode_q      <= '0;
            param_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            mode_q      <= mode_d;
            param_q     <= param_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign beat_cnt     = beat_cnt_q;
endmodule
